// File: rtl/taxi_arb_pkg.sv
// Shared definitions for the taxi arbiter family.
//   arb_state_t  : arbiter FSM state (idle / grant active)
//   rr_mask()    : round-robin mask that follows a grant to a given index
package taxi_arb_pkg;

  // Widest port count the mask helper supports; callers slice the result.
  localparam int ARB_MAX_PORTS = 32;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Ports still eligible for the masked search after granting 'index'.
  // When the highest index has priority, the rotation continues downwards,
  // so only the ports below the winner stay in the mask; with the lowest
  // index having priority it continues upwards instead.
  function automatic logic [ARB_MAX_PORTS-1:0] rr_mask(input int index,
                                                       input logic lsb_high_prio);
    logic [ARB_MAX_PORTS-1:0] m;
    m = '0;
    for (int k = 0; k < ARB_MAX_PORTS; k++) begin
      if (lsb_high_prio ? (k > index) : (k < index)) begin
        m[k] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/taxi_arbiter_wrr_if.sv
// Bus between the requesters and the weighted round-robin arbiter.
//   req, ack, weight                         : requester side -> arbiter
//   grant_valid, grant, grant_index, credit  : arbiter -> requester side
//   state                                    : arbiter FSM state (debug)
//
// Handshake: a port raises req[i] and keeps it high while it wants the
// resource. Once grant[i] is seen, each cycle with ack[i] high is one
// transferred beat. The grant is held until credit beats have been acked
// or the port drops req[i]; ack on a port that is not granted has no effect.
interface taxi_arbiter_wrr_if
  import taxi_arb_pkg::*;
#(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0]    req;
  logic [PORTS-1:0]    ack;
  logic [WEIGHT_W-1:0] weight [PORTS];
  logic                grant_valid;
  logic [PORTS-1:0]    grant;
  logic [IDX_W-1:0]    grant_index;
  logic [WEIGHT_W-1:0] credit;
  arb_state_t          state;

  modport master (
    output req, ack, weight,
    input  grant_valid, grant, grant_index, credit, state
  );

  modport slave (
    input  req, ack, weight,
    output grant_valid, grant, grant_index, credit, state
  );

endinterface

// File: rtl/taxi_penc.sv
// Priority encoder.
//   input_unencoded  : request vector
//   output_valid     : at least one input bit set
//   output_encoded   : index of the winning bit
//   output_unencoded : one-hot of the winning bit (zero when not valid)
// LSB_HIGH_PRIO = 0 lets the highest set index win, 1 the lowest.
module taxi_penc #(
  parameter int   WIDTH         = 4,
  parameter logic LSB_HIGH_PRIO = 1'b0,
  localparam int  IDX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] input_unencoded,
  output logic             output_valid,
  output logic [IDX_W-1:0] output_encoded,
  output logic [WIDTH-1:0] output_unencoded
);

  always_comb begin
    output_valid     = 1'b0;
    output_encoded   = '0;
    output_unencoded = '0;
    // Scan so that the preferred end is visited last and overwrites others.
    if (LSB_HIGH_PRIO) begin
      for (int k = WIDTH - 1; k >= 0; k--) begin
        if (input_unencoded[k]) begin
          output_valid   = 1'b1;
          output_encoded = IDX_W'(k);
        end
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (input_unencoded[k]) begin
          output_valid   = 1'b1;
          output_encoded = IDX_W'(k);
        end
      end
    end
    if (output_valid) begin
      output_unencoded[output_encoded] = 1'b1;
    end
  end

endmodule

// File: rtl/taxi_arbiter_wrr.sv
// Weighted round-robin arbiter with per-port burst quotas.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : taxi_arbiter_wrr_if.slave
//                req/ack/weight in, grant_valid/grant/grant_index/credit out,
//                state (FSM debug) out
// A winner keeps the grant for up to max(weight,1) acked beats or until it
// drops req, then the next port is chosen in the same cycle so the new grant
// appears on the following edge with no idle cycle. All outputs registered.
module taxi_arbiter_wrr
  import taxi_arb_pkg::*;
#(
  parameter int   PORTS         = 4,
  parameter int   WEIGHT_W      = 4,
  parameter logic LSB_HIGH_PRIO = 1'b0,
  localparam int  IDX_W         = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  taxi_arbiter_wrr_if.slave  bus
);

  arb_state_t          state_reg, state_next;
  logic [PORTS-1:0]    grant_reg, grant_next;
  logic [IDX_W-1:0]    index_reg, index_next;
  logic [WEIGHT_W-1:0] credit_reg, credit_next;
  logic [PORTS-1:0]    mask_reg, mask_next;

  // Candidate selection: masked search first, fall back to unmasked.
  logic             m_valid, u_valid;
  logic [IDX_W-1:0] m_index, u_index;
  logic [PORTS-1:0] m_onehot, u_onehot;

  taxi_penc #(
    .WIDTH         (PORTS),
    .LSB_HIGH_PRIO (LSB_HIGH_PRIO)
  ) u_penc_masked (
    .input_unencoded  (bus.req & mask_reg),
    .output_valid     (m_valid),
    .output_encoded   (m_index),
    .output_unencoded (m_onehot)
  );

  taxi_penc #(
    .WIDTH         (PORTS),
    .LSB_HIGH_PRIO (LSB_HIGH_PRIO)
  ) u_penc_unmasked (
    .input_unencoded  (bus.req),
    .output_valid     (u_valid),
    .output_encoded   (u_index),
    .output_unencoded (u_onehot)
  );

  logic                     pick_valid;
  logic [IDX_W-1:0]         pick_index;
  logic [PORTS-1:0]         pick_onehot;
  logic [WEIGHT_W-1:0]      pick_weight;
  logic [ARB_MAX_PORTS-1:0] pick_mask;
  logic                     beat;
  logic                     arbitrate;

  always_comb begin
    pick_valid  = 1'b0;
    pick_index  = '0;
    pick_onehot = '0;
    pick_weight = '0;
    pick_mask   = '0;
    beat        = 1'b0;
    arbitrate   = 1'b0;
    state_next  = state_reg;
    grant_next  = grant_reg;
    index_next  = index_reg;
    credit_next = credit_reg;
    mask_next   = mask_reg;

    if (m_valid) begin
      pick_valid  = 1'b1;
      pick_index  = m_index;
      pick_onehot = m_onehot;
    end else if (u_valid) begin
      pick_valid  = 1'b1;
      pick_index  = u_index;
      pick_onehot = u_onehot;
    end
    pick_weight = bus.weight[pick_index];
    pick_mask   = rr_mask(int'(pick_index), LSB_HIGH_PRIO);

    case (state_reg)
      ARB_IDLE: begin
        arbitrate = 1'b1;
      end
      ARB_GRANT: begin
        beat = bus.ack[index_reg];
        if (beat) begin
          credit_next = credit_reg - WEIGHT_W'(1);
        end
        // Quota spent on this beat, or the port went away without a beat.
        // A beat coinciding with a req drop is counted; the drop is then
        // seen on the following cycle unless the quota already ran out.
        if ((beat && credit_reg == WEIGHT_W'(1)) ||
            (!bus.req[index_reg] && !beat)) begin
          arbitrate = 1'b1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase

    if (arbitrate) begin
      if (pick_valid) begin
        state_next  = ARB_GRANT;
        grant_next  = pick_onehot;
        index_next  = pick_index;
        credit_next = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
        mask_next   = pick_mask[PORTS-1:0];
      end else begin
        state_next  = ARB_IDLE;
        grant_next  = '0;
        credit_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ARB_IDLE;
      grant_reg  <= '0;
      index_reg  <= '0;
      credit_reg <= '0;
      mask_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      index_reg  <= index_next;
      credit_reg <= credit_next;
      mask_reg   <= mask_next;
    end
  end

  assign bus.grant_valid = (state_reg == ARB_GRANT);
  assign bus.grant       = grant_reg;
  assign bus.grant_index = index_reg;
  assign bus.credit      = credit_reg;
  assign bus.state       = state_reg;

endmodule

// File: tb/tb_taxi_arbiter_wrr.sv
// Directed bench for taxi_arbiter_wrr (PORTS=4, WEIGHT_W=4, highest index wins).
module tb_taxi_arbiter_wrr;
  import taxi_arb_pkg::*;

  localparam int PORTS    = 4;
  localparam int WEIGHT_W = 4;
  localparam int IDX_W    = 2;

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  taxi_arbiter_wrr_if #(.PORTS(PORTS), .WEIGHT_W(WEIGHT_W)) bus ();

  taxi_arbiter_wrr #(
    .PORTS         (PORTS),
    .WEIGHT_W      (WEIGHT_W),
    .LSB_HIGH_PRIO (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input int w3, input int w2, input int w1, input int w0);
    bus.weight[3] = WEIGHT_W'(w3);
    bus.weight[2] = WEIGHT_W'(w2);
    bus.weight[1] = WEIGHT_W'(w1);
    bus.weight[0] = WEIGHT_W'(w0);
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.ack = '0;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
  endtask

  // Pops expected indices and checks them one per cycle.
  task automatic run_seq(input string tag);
    logic [IDX_W-1:0] e;
    logic [PORTS-1:0] one;
    while (exp_q.size() > 0) begin
      tick();
      e   = exp_q.pop_front();
      one = '0;
      one[e] = 1'b1;
      check({tag, "_idx"}, 32'(bus.grant_index), 32'(e));
      check({tag, "_grant"}, 32'(bus.grant), 32'(one));
      check({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;
    bus.ack = '0;
    set_weights(1, 1, 1, 1);

    // 1: reset holds outputs low under random inputs, then first grant
    set_weights(1, 3, 1, 1);
    for (int i = 0; i < 4; i++) begin
      bus.req = PORTS'($urandom_range(0, 15));
      bus.ack = PORTS'($urandom_range(0, 15));
      tick();
      check("rst_valid", 32'(bus.grant_valid), 32'd0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_index", 32'(bus.grant_index), 32'd0);
      check("rst_credit", 32'(bus.credit), 32'd0);
      check("rst_state", 32'(bus.state), 32'(ARB_IDLE));
    end
    bus.req = 4'b0100;
    bus.ack = '0;
    rst_n   = 1'b1;
    tick();
    check("t1_grant", 32'(bus.grant), 32'b0100);
    check("t1_index", 32'(bus.grant_index), 32'd2);
    check("t1_credit", 32'(bus.credit), 32'd3);
    check("t1_state", 32'(bus.state), 32'(ARB_GRANT));

    // 2: sole requester with weight 3 -> 3,2,1 then reload 3, grant held
    do_reset();
    set_weights(1, 3, 1, 1);
    bus.req = 4'b0100;
    tick();
    check("t2_credit0", 32'(bus.credit), 32'd3);
    bus.ack = 4'b0100;
    tick();
    check("t2_credit1", 32'(bus.credit), 32'd2);
    tick();
    check("t2_credit2", 32'(bus.credit), 32'd1);
    tick();
    check("t2_reload", 32'(bus.credit), 32'd3);
    check("t2_valid", 32'(bus.grant_valid), 32'd1);
    check("t2_grant", 32'(bus.grant), 32'b0100);

    // 3: all request, weight 1, ack every cycle
    do_reset();
    set_weights(1, 1, 1, 1);
    bus.req = 4'b1111;
    bus.ack = 4'b1111;
    exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
    run_seq("t3");

    // 4: weights {3:2, 2:1, 1:0, 0:3}
    do_reset();
    set_weights(2, 1, 0, 3);
    bus.req = 4'b1111;
    bus.ack = 4'b1111;
    exp_q = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    run_seq("t4");
    check("t4_credit_w0a", 32'(bus.credit), 32'd3);
    tick();
    check("t4_credit_w0b", 32'(bus.credit), 32'd2);
    tick();
    check("t4_credit_w0c", 32'(bus.credit), 32'd1);
    exp_q = '{2'd3};
    run_seq("t4_wrap");
    check("t4_credit_w3", 32'(bus.credit), 32'd2);

    // 5: request drop without ack moves on; no requester -> idle
    do_reset();
    set_weights(1, 1, 4, 2);
    bus.req = 4'b0010;
    tick();
    check("t5_index1", 32'(bus.grant_index), 32'd1);
    check("t5_credit4", 32'(bus.credit), 32'd4);
    bus.req = 4'b0001;
    tick();
    check("t5_index0", 32'(bus.grant_index), 32'd0);
    check("t5_grant0", 32'(bus.grant), 32'b0001);
    check("t5_credit0", 32'(bus.credit), 32'd2);
    bus.ack = 4'b1000;  // ack on a non-granted port must not count
    tick();
    check("t5_stray_ack", 32'(bus.credit), 32'd2);
    bus.req = '0;
    bus.ack = '0;
    tick();
    check("t5_idle_valid", 32'(bus.grant_valid), 32'd0);
    check("t5_idle_grant", 32'(bus.grant), 32'd0);
    check("t5_idle_state", 32'(bus.state), 32'(ARB_IDLE));

    // 6: async reset mid-grant, then rearbitration from a clear mask
    do_reset();
    set_weights(3, 1, 1, 1);
    bus.req = 4'b1000;
    tick();
    bus.ack = 4'b1000;
    tick();
    check("t6_credit2", 32'(bus.credit), 32'd2);
    bus.ack = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.grant_valid), 32'd0);
    check("t6_async_grant", 32'(bus.grant), 32'd0);
    check("t6_async_credit", 32'(bus.credit), 32'd0);
    check("t6_async_state", 32'(bus.state), 32'(ARB_IDLE));
    bus.req = 4'b1111;
    #1;
    rst_n = 1'b1;
    tick();
    check("t6_rearb_index", 32'(bus.grant_index), 32'd3);
    check("t6_rearb_credit", 32'(bus.credit), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/taxi_arbiter_wrr.md
# taxi_arbiter_wrr

Weighted round-robin arbiter with per-port burst quotas, for shared-resource muxes (MAC TX/RX stream mux, register bus fabrics) where ports need unequal bandwidth shares. Each winner holds the grant for up to `weight[i]` acknowledged beats, or until it drops its request, and then yields. Output is registered and rearbitration is back-to-back with no idle cycle. It is the weighted successor to the plain round-robin arbiter and is built on the same `taxi_penc` priority encoder.

## Interface
- `PORTS`, 4, number of requesters (≥2)
- `WEIGHT_W`, 4, width of per-port weight and credit counter
- `LSB_HIGH_PRIO`, 1'b0, base priority direction for the encoder; 0 means highest index wins
- `clk` in 1, single clock
- `rst_n` in 1, reset, asynchronous and active-low
- `req` in `PORTS`, request per port
- `ack` in `PORTS`, beat acknowledge per port; only the granted bit is used
- `weight` in `PORTS`×`WEIGHT_W` (unpacked array `[PORTS]`), beat quota per port; 0 is treated as 1
- `grant_valid` out 1, a grant is active
- `grant` out `PORTS`, one-hot grant
- `grant_index` out `$clog2(PORTS)`, index of granted port
- `credit` out `WEIGHT_W`, beats remaining in the current grant

## Operation
- States:
  - IDLE: `grant_valid`=0.
  - GRANT: `grant_valid`=1.
- Selection when arbitrating:
  - First try `req & mask_reg` through the masked `taxi_penc`. If none is found, use the unmasked `taxi_penc`.
  - After granting index i:
    - MSB-prio: `mask_reg` = ports below i.
    - LSB-prio: `mask_reg` = ports above i.
- On each new grant, `credit` loads `max(weight[i],1)`. `weight` is sampled only at that point.
- Beat: a cycle with `grant_valid && ack[grant_index]`. Each beat decrements `credit`.
- Release conditions for the current grant:
  - (a) beat while `credit`==1 (quota exhausted);
  - (b) `req[grant_index]`==0 in a cycle with no beat.
  - A beat that lands in the same cycle as a request drop counts, and release follows rule (a) or the next cycle.
- On release, arbitration runs in the same cycle using the already-updated mask.
  - If another port requests, it is granted next cycle.
  - If the released port is the sole requester, it is regranted with a reloaded credit and `grant_valid` stays 1.
  - If no port requests, go to IDLE.
- `ack` on non-granted ports and `ack` while IDLE are ignored.
- `credit` never wraps below 0. Release at 1 guarantees this.

## Timing
- Reset values (asynchronous, while `rst_n`=0): `grant_valid`=0, `grant`=0, `grant_index`=0, `credit`=0, `mask_reg`=0, state IDLE.
- Deassertion of `rst_n` is synchronised by the integrator. The first edge after release behaves as IDLE.
- Latency:
  - `req` rising in IDLE at edge N gives grant at N+1.
  - Release at edge N gives the new grant at N+1, with zero bubble.
- `grant`, `grant_index`, `grant_valid` and `credit` change only at clock edges. All outputs are registered.
- Reset asserted mid-grant clears outputs immediately. Remaining credit is discarded.

## Structure
- Shared package `taxi_arb_pkg`:
  - state enum (`ARB_IDLE`, `ARB_GRANT`);
  - helper function `rr_mask(index, lsb_high_prio)` returning the next round-robin mask.
- Sub-module: `taxi_penc`, instantiated twice (masked and unmasked). No new sub-module.
- Credit counter, state and mask live in one always_ff with async reset. Next-state logic is in one always_comb.

## Test plan
1. Hold `rst_n`=0 with random `req`/`ack` → all outputs 0. Release `rst_n`, `req`=4'b0100 → `grant`=4'b0100, `grant_index`=2, `credit`=`weight[2]` one cycle after the first edge.
2. Only port 2 requests, `weight[2]`=3, `ack[2]` held high → `credit` goes 3,2,1, then reloads to 3 with `grant_valid` held 1 and `grant` unchanged.
3. All `req`=1, all weights 1, `ack` every cycle, MSB-prio → grant index sequence 3,2,1,0,3,2… with no idle cycle.
4. All `req`=1, weights {w3=2, w2=1, w1=0, w0=3}, `ack` every cycle → index sequence 3,3,2,1,0,0,0,3; w1=0 behaves as 1.
5. Port 1 granted with `credit`=4, `req[1]` dropped with no ack, `req[0]`=1 → next cycle `grant_index`=0. With no other requester → `grant_valid`=0 next cycle.
6. `rst_n` pulsed low mid-grant with `credit`=2 → outputs clear without waiting for a clock edge. After release, rearbitration starts with `mask_reg`=0 (port 3 wins among all requesting).
